// File: rtl/layer_cfg_pkg.sv
// Shared layer-descriptor layout, error codes, sequencer state encoding and the
// output-feature-map size rule used by the sequencer and by golden models.
package layer_cfg_pkg;

    localparam int unsigned DESC_W     = 37;
    localparam int unsigned IFM_SIZE_W = 9;
    localparam int unsigned IFM_CH_W   = 11;
    localparam int unsigned KSIZE_W    = 2;
    localparam int unsigned NFILT_W    = 11;
    localparam int unsigned STRIDE_W   = 2;
    localparam int unsigned OFM_W      = 10;
    localparam int unsigned ERR_W      = 3;

    localparam int unsigned IFM_SIZE_LSB = 28;
    localparam int unsigned IFM_CH_LSB   = 17;
    localparam int unsigned KSIZE_LSB    = 15;
    localparam int unsigned NFILT_LSB    = 4;
    localparam int unsigned MP_MODE_BIT  = 3;
    localparam int unsigned STRIDE_LSB   = 1;
    localparam int unsigned UP_MODE_BIT  = 0;

    // Field order matches the bit offsets above, MSB first.
    typedef struct packed {
        logic [IFM_SIZE_W-1:0] ifm_size;
        logic [IFM_CH_W-1:0]   ifm_channel;
        logic [KSIZE_W-1:0]    kernel_size;
        logic [NFILT_W-1:0]    num_filter;
        logic                  maxpool_mode;
        logic [STRIDE_W-1:0]   maxpool_stride;
        logic                  upsample_mode;
    } layer_desc_t;

    localparam logic [ERR_W-1:0] ERR_NONE    = 3'd0;
    localparam logic [ERR_W-1:0] ERR_KERNEL  = 3'd1;
    localparam logic [ERR_W-1:0] ERR_STRIDE  = 3'd2;
    localparam logic [ERR_W-1:0] ERR_MODE    = 3'd3;
    localparam logic [ERR_W-1:0] ERR_CHAIN   = 3'd4;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 3'd5;
    localparam logic [ERR_W-1:0] ERR_RANGE   = 3'd6;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCheck    = 3'd1,
        StLaunch   = 3'd2,
        StWaitDone = 3'd3,
        StNext     = 3'd4,
        StFinish   = 3'd5,
        StError    = 3'd6
    } seq_state_e;

    // Valid-conv output size, then exactly one of upsample x2 / pool-by-2 / pass.
    function automatic logic [OFM_W-1:0] ofm_size(input layer_desc_t d);
        logic [OFM_W-1:0] base;
        base = OFM_W'(d.ifm_size) - OFM_W'(d.kernel_size) + OFM_W'(1);
        if (d.upsample_mode) begin
            ofm_size = base << 1;
        end else if (d.maxpool_mode && (d.maxpool_stride == 2'd2)) begin
            ofm_size = base >> 1;
        end else begin
            ofm_size = base;
        end
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Link between the layer sequencer and the conv/maxpool/upsample TOP:
// per-layer configuration, start pulse and done.
interface layer_sequencer_if;
    import layer_cfg_pkg::*;

    logic                  top_start;
    logic                  top_done;
    logic [IFM_SIZE_W-1:0] ifm_size;
    logic [IFM_CH_W-1:0]   ifm_channel;
    logic [KSIZE_W-1:0]    kernel_size;
    logic [NFILT_W-1:0]    num_filter;
    logic                  maxpool_mode;
    logic [STRIDE_W-1:0]   maxpool_stride;
    logic                  upsample_mode;

    modport master (
        output top_start,
        output ifm_size,
        output ifm_channel,
        output kernel_size,
        output num_filter,
        output maxpool_mode,
        output maxpool_stride,
        output upsample_mode,
        input  top_done
    );

    modport slave (
        input  top_start,
        input  ifm_size,
        input  ifm_channel,
        input  kernel_size,
        input  num_filter,
        input  maxpool_mode,
        input  maxpool_stride,
        input  upsample_mode,
        output top_done
    );

endinterface

// File: rtl/layer_desc_check.sv
// Combinational descriptor validator: resulting ofm size and the first
// applicable error cause for one layer.
module layer_desc_check
    import layer_cfg_pkg::*;
(
    input  layer_desc_t      desc,
    input  logic             first_layer,
    input  logic [OFM_W-1:0] prev_ofm,
    output logic [ERR_W-1:0] err_code,
    output logic [OFM_W-1:0] ofm
);

    logic kernel_ok;
    logic stride_ok;
    logic chain_ok;
    logic range_ok;

    always_comb begin
        kernel_ok = (desc.kernel_size == 2'd1) || (desc.kernel_size == 2'd3);
        stride_ok = (desc.maxpool_stride == 2'd1) || (desc.maxpool_stride == 2'd2);
        chain_ok  = first_layer || (OFM_W'(desc.ifm_size) == prev_ofm);
        range_ok  = (desc.ifm_size >= IFM_SIZE_W'(desc.kernel_size)) &&
                    (desc.ifm_channel != '0) && (desc.num_filter != '0);
    end

    always_comb begin
        ofm      = ofm_size(desc);
        err_code = ERR_NONE;
        if (!kernel_ok) begin
            err_code = ERR_KERNEL;
        end else if (desc.maxpool_mode && !stride_ok) begin
            err_code = ERR_STRIDE;
        end else if (desc.maxpool_mode && desc.upsample_mode) begin
            err_code = ERR_MODE;
        end else if (!chain_ok) begin
            err_code = ERR_CHAIN;
        end else if (!range_ok) begin
            err_code = ERR_RANGE;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks a table of layer descriptors, validating each one, launching TOP and
// timing it until done; reports progress, completion and error causes.
module layer_sequencer
    import layer_cfg_pkg::*;
#(
    parameter int unsigned MAX_LAYERS = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned CYC_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DESC_W-1:0] cfg_wdata,
    input  logic [ADDR_W:0]   num_layers,
    input  logic [CYC_W-1:0]  timeout_cycles,
    input  logic              run,
    input  logic              abort,
    input  logic              err_clear,
    layer_sequencer_if.master top,
    output logic              busy,
    output logic [ADDR_W-1:0] layer_idx,
    output logic [CYC_W-1:0]  layer_cycles,
    output logic              all_done,
    output logic              err,
    output logic [ERR_W-1:0]  err_code
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   nl_q, nl_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;
    logic [CYC_W-1:0]  lcyc_q, lcyc_d;
    logic [ERR_W-1:0]  errc_q, errc_d;
    logic [OFM_W-1:0]  prev_ofm_q, prev_ofm_d;
    layer_desc_t       cfg_q, cfg_d;
    logic              done_d_q;

    layer_desc_t       desc_mem [MAX_LAYERS];
    layer_desc_t       cur_desc;
    logic              first_layer;
    logic [ERR_W-1:0]  chk_err;
    logic [OFM_W-1:0]  chk_ofm;

    logic              start;
    logic              finish_pulse;
    logic              done_edge;
    logic              range_ok;
    logic              last_layer;
    logic [CYC_W-1:0]  cnt_inc;

    // Table contents survive reset; only the host write port touches them.
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && !busy) begin
            desc_mem[cfg_addr] <= layer_desc_t'(cfg_wdata);
        end
    end

    assign cur_desc    = desc_mem[idx_q];
    assign first_layer = (idx_q == '0);

    layer_desc_check u_check (
        .desc        (cur_desc),
        .first_layer (first_layer),
        .prev_ofm    (prev_ofm_q),
        .err_code    (chk_err),
        .ofm         (chk_ofm)
    );

    assign busy       = (state_q != StIdle) && (state_q != StError);
    assign done_edge  = top.top_done && !done_d_q;
    assign range_ok   = (num_layers != '0) && (num_layers <= (ADDR_W + 1)'(MAX_LAYERS));
    assign last_layer = ({1'b0, idx_q} == (nl_q - (ADDR_W + 1)'(1)));
    assign cnt_inc    = cnt_q + CYC_W'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nl_d         = nl_q;
        cnt_d        = cnt_q;
        lcyc_d       = lcyc_q;
        errc_d       = errc_q;
        prev_ofm_d   = prev_ofm_q;
        cfg_d        = cfg_q;
        start        = 1'b0;
        finish_pulse = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    if (range_ok) begin
                        nl_d    = num_layers;
                        idx_d   = '0;
                        state_d = StCheck;
                    end else begin
                        errc_d  = ERR_RANGE;
                        state_d = StError;
                    end
                end
            end
            StCheck: begin
                cfg_d      = cur_desc;
                prev_ofm_d = chk_ofm;
                if (chk_err != ERR_NONE) begin
                    errc_d  = chk_err;
                    state_d = StError;
                end else begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // A done edge in the timeout cycle still completes the layer.
                if (done_edge) begin
                    lcyc_d  = cnt_inc;
                    state_d = StNext;
                end else if ((timeout_cycles != '0) && (cnt_inc == timeout_cycles)) begin
                    errc_d  = ERR_TIMEOUT;
                    state_d = StError;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StNext: begin
                if (last_layer) begin
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StCheck;
                end
            end
            StFinish: begin
                finish_pulse = 1'b1;
                state_d      = StIdle;
            end
            StError: begin
                if (err_clear) begin
                    errc_d  = ERR_NONE;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards whatever the busy state would have done this cycle.
        if (abort && busy) begin
            state_d      = StIdle;
            idx_d        = idx_q;
            nl_d         = nl_q;
            cnt_d        = cnt_q;
            lcyc_d       = lcyc_q;
            errc_d       = errc_q;
            prev_ofm_d   = prev_ofm_q;
            cfg_d        = cfg_q;
            start        = 1'b0;
            finish_pulse = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            nl_q       <= '0;
            cnt_q      <= '0;
            lcyc_q     <= '0;
            errc_q     <= ERR_NONE;
            prev_ofm_q <= '0;
            cfg_q      <= '0;
            done_d_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nl_q       <= nl_d;
            cnt_q      <= cnt_d;
            lcyc_q     <= lcyc_d;
            errc_q     <= errc_d;
            prev_ofm_q <= prev_ofm_d;
            cfg_q      <= cfg_d;
            done_d_q   <= top.top_done;
        end
    end

    assign top.top_start      = start;
    assign top.ifm_size       = cfg_q.ifm_size;
    assign top.ifm_channel    = cfg_q.ifm_channel;
    assign top.kernel_size    = cfg_q.kernel_size;
    assign top.num_filter     = cfg_q.num_filter;
    assign top.maxpool_mode   = cfg_q.maxpool_mode;
    assign top.maxpool_stride = cfg_q.maxpool_stride;
    assign top.upsample_mode  = cfg_q.upsample_mode;

    assign layer_idx    = idx_q;
    assign layer_cycles = lcyc_q;
    assign all_done     = finish_pulse;
    assign err          = (state_q == StError);
    assign err_code     = errc_q;

endmodule
